synapse_selector_wrapper: RTL and testbench

- Fetches the outgoing synapse row of one presynaptic neuron from a weight BRAM.
- Streams (postIndex, weight) pairs, one per clock, to the downstream neuron-update logic.
- Row base address = baseAddr + preIndex*postsynCount.
- Reads use a combinational-read memory port; start/busy/done control handshake.

---
 rtl/synapse_selector_wrapper.sv | 151 +++++++++++++++
 tb/tb_synapse_selector_wrapper.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/synapse_selector_wrapper.sv
// synapse_selector_wrapper: walks one presynaptic neuron's row in the weight
// memory and emits (postIndex, weight) pairs, one per clock.
// Optional build macro: SYNSEL_ZERO_SKIP_EN -- when defined, words whose weight
// field is zero are read but do not update postIndex/weight.
//
// Handshake: start is sampled only in IDLE; when accepted, preIndex,
// postsynCount and baseAddr are latched. busy is high in CALC and READ, done
// pulses for exactly one cycle in DONE, and start seen outside IDLE is ignored.
// The memory port is combinational: mem_data must be valid in the same cycle
// that mem_en/mem_addr are presented.
module synapse_selector_wrapper #(
  parameter int ADDR_W   = 12,
  parameter int IDX_W    = 8,
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IDX_W-1:0]    preIndex,
  input  logic [IDX_W-1:0]    postsynCount,
  input  logic [ADDR_W-1:0]   baseAddr,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    postIndex,
  output logic [WEIGHT_W-1:0] weight,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_en,
  input  logic [DATA_W-1:0]   mem_data,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W-1:0]     row_base_q, row_base_d;
  logic [IDX_W-1:0]      j_q, j_d;
  logic [IDX_W-1:0]      post_q, post_d;
  logic [WEIGHT_W-1:0]   weight_q, weight_d;
  logic [2*IDX_W-1:0]    row_prod;
  logic                  capture_en;
  logic                  last_read;
  logic                  unused_mem_hi;

  // The high part of the memory word carries no weight information.
  assign unused_mem_hi = ^mem_data[DATA_W-1:WEIGHT_W];

  // Full-width product; truncation to the address width happens when it is
  // added to the base, so the row base wraps modulo 2^ADDR_W.
  assign row_prod = pre_q * cnt_q;

  // Compare before incrementing so a count of 255 never needs a wider counter.
  assign last_read = (j_q == (cnt_q - 1'b1));

  // Decide whether the word on the bus updates the visible outputs.
  always_comb begin
    capture_en = 1'b1;
`ifdef SYNSEL_ZERO_SKIP_EN
    capture_en = (mem_data[WEIGHT_W-1:0] != '0);
`endif
  end

  // State register plus latched request and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pre_q      <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      row_base_q <= '0;
      j_q        <= '0;
      post_q     <= '0;
      weight_q   <= '0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      row_base_q <= row_base_d;
      j_q        <= j_d;
      post_q     <= post_d;
      weight_q   <= weight_d;
    end
  end

  // Next-state, datapath next values and outputs.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    row_base_d = row_base_q;
    j_d        = j_q;
    post_d     = post_q;
    weight_d   = weight_q;
    busy       = 1'b0;
    done       = 1'b0;
    mem_en     = 1'b0;
    mem_addr   = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pre_d   = preIndex;
          cnt_d   = postsynCount;
          base_d  = baseAddr;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        busy       = 1'b1;
        row_base_d = base_q + row_prod[ADDR_W-1:0];
        j_d        = '0;
        state_d    = (cnt_q == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_addr = row_base_q + ADDR_W'(j_q);
        if (capture_en) begin
          weight_d = mem_data[WEIGHT_W-1:0];
          post_d   = j_q;
        end
        j_d = j_q + 1'b1;
        if (last_read) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign postIndex   = post_q;
  assign weight      = weight_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_synapse_selector_wrapper.sv
// Bench for synapse_selector_wrapper: directed rows from the test plan, a
// mid-row reset, then randomized rows against a row-walk reference model.
module tb_synapse_selector_wrapper;

  localparam int AW = 12;
  localparam int IW = 8;
  localparam int DW = 32;
  localparam int WW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start;
  logic [IW-1:0] preIndex;
  logic [IW-1:0] postsynCount;
  logic [AW-1:0] baseAddr;
  logic          busy;
  logic          done;
  logic [IW-1:0] postIndex;
  logic [WW-1:0] weight;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic [DW-1:0] mem_data;
  logic [1:0]    dbg_state;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign mem_data = mem[mem_addr];

  synapse_selector_wrapper #(
    .ADDR_W(AW), .IDX_W(IW), .DATA_W(DW), .WEIGHT_W(WW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .preIndex(preIndex), .postsynCount(postsynCount), .baseAddr(baseAddr),
    .busy(busy), .done(done), .postIndex(postIndex), .weight(weight),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int            n_vec = 0;
  int            n_err = 0;
  logic [AW-1:0] exp_q[$];
  logic [IW-1:0] m_post;
  logic [WW-1:0] m_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_skips(input logic [DW-1:0] w);
`ifdef SYNSEL_ZERO_SKIP_EN
    return (w[WW-1:0] == '0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic fill_mem_pattern();
    for (int k = 0; k < (1 << AW); k++) begin
      mem[k] = {16'(k + 1000), 16'(k + 2000)};
    end
  endtask

  task automatic fill_mem_random();
    for (int k = 0; k < (1 << AW); k++) begin
      mem[k] = $urandom;
      if ($urandom_range(0, 7) == 0) mem[k][WW-1:0] = '0;
    end
  endtask

  task automatic scramble_inputs();
    preIndex     = IW'($urandom);
    postsynCount = IW'($urandom);
    baseAddr     = AW'($urandom);
  endtask

  // ---------------- driver ----------------
  // Issues one row request with start high for `hold` cycles (1 or 2) and
  // checks every cycle until the block is back in IDLE.
  task automatic run_row(input int pre, input int cnt, input int base, input int hold);
    logic [AW-1:0] a;
    for (int k = 0; k < cnt; k++) begin
      a = AW'((base + pre * cnt + k) % (1 << AW));
      exp_q.push_back(a);
    end
    @(negedge clk);
    start        = 1'b1;
    preIndex     = IW'(pre);
    postsynCount = IW'(cnt);
    baseAddr     = AW'(base);
    @(negedge clk);
    if (hold < 2) start = 1'b0;
    scramble_inputs();
    check("calc_busy", 32'(busy), 32'd1);
    check("calc_mem_en", 32'(mem_en), 32'd0);
    check("calc_done", 32'(done), 32'd0);
    for (int k = 0; k < cnt; k++) begin
      @(negedge clk);
      start = 1'b0;
      a = exp_q.pop_front();
      check("rd_mem_en", 32'(mem_en), 32'd1);
      check("rd_addr", 32'(mem_addr), 32'(a));
      check("rd_busy", 32'(busy), 32'd1);
      check("rd_done", 32'(done), 32'd0);
      check("rd_post", 32'(postIndex), 32'(m_post));
      check("rd_weight", 32'(weight), 32'(m_w));
      if (!model_skips(mem[a])) begin
        m_post = IW'(k);
        m_w    = mem[a][WW-1:0];
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_mem_en", 32'(mem_en), 32'd0);
    check("done_post", 32'(postIndex), 32'(m_post));
    check("done_weight", 32'(weight), 32'(m_w));
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_mem_en", 32'(mem_en), 32'd0);
    check("idle_addr", 32'(mem_addr), 32'd0);
  endtask

  // Starts a row and pulls reset low partway into the third read cycle.
  task automatic run_reset_mid_row();
    @(negedge clk);
    start = 1'b1; preIndex = 8'd3; postsynCount = 8'd8; baseAddr = 12'h040;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_mem_en", 32'(mem_en), 32'd1);
    #1 rst = 1'b0;
    #1;
    m_post = '0;
    m_w    = '0;
    exp_q.delete();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_post", 32'(postIndex), 32'd0);
    check("rst_weight", 32'(weight), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0; start = 1'b0;
    preIndex = '0; postsynCount = '0; baseAddr = '0;
    m_post = '0; m_w = '0;
    fill_mem_pattern();
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_post", 32'(postIndex), 32'd0);
    check("reset_weight", 32'(weight), 32'd0);
    check("reset_mem_en", 32'(mem_en), 32'd0);
    check("reset_addr", 32'(mem_addr), 32'd0);
    rst = 1'b1;

    run_row(3, 8, 'h040, 1);
    run_row(3, 8, 'h040, 2);
    run_row(5, 0, 'h123, 1);
    run_row(0, 4, 'hFFE, 1);
    run_reset_mid_row();
    run_row(3, 8, 'h040, 1);
    mem[90][WW-1:0] = '0;
    run_row(3, 8, 'h040, 1);

    fill_mem_random();
    for (int r = 0; r < 25; r++) begin
      run_row($urandom_range(0, 255), $urandom_range(0, 20),
              $urandom_range(0, (1 << AW) - 1), $urandom_range(1, 2));
    end
    run_row($urandom_range(0, 255), 255, $urandom_range(0, (1 << AW) - 1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
